led_trace_tx: RTL and testbench
===============================

LED_TRACE_TX -- requirements
Module: led_trace_tx

Interface
REQ-001 Parameter BAUD_DIV, default 16: clock cycles per serial bit, legal range 2..255.
REQ-002 Parameter DEPTH, default 4: FIFO entries, power of two, legal range 2..16.
REQ-003 Port Clock  input  1: single clock; all state updates on its rising edge.
REQ-004 Port Reset  input  1: synchronous, active-high reset.
REQ-005 Port iLed  input  8: LED byte from the MiniAlu oLed output, synchronous to Clock.
REQ-006 Port oTx  output  1: serial line, idle high.
REQ-007 Port oBusy  output  1: high while a frame is on oTx or the FIFO is non-empty.
REQ-008 Port oOverflow  output  1: sticky flag; a change was dropped because the FIFO was full.

Function
REQ-009 The block SHALL hold rLast, an 8-bit copy of the last sampled iLed, updated every edge.
REQ-010 At edge E with iLed != rLast, the block SHALL write iLed into the FIFO at that same edge (change event).
REQ-011 The FIFO SHALL be DEPTH entries, first-in first-out; pointers SHALL wrap modulo DEPTH; the count SHALL range 0..DEPTH.
REQ-012 The transmitter FSM SHALL have states IDLE, START, DATA, STOP and, when configured, PARITY.
REQ-013 In IDLE with the FIFO non-empty at edge E, the FSM SHALL pop one entry, load the shift register, and enter START; oTx SHALL be 0 from edge E onward.
REQ-014 Each of START, each DATA bit, PARITY and STOP SHALL last exactly BAUD_DIV cycles, counted by a down-counter reloaded on every bit boundary.
REQ-015 DATA SHALL send 8 bits LSB first; STOP SHALL drive oTx=1; a frame SHALL be 10*BAUD_DIV cycles (11*BAUD_DIV with parity).
REQ-016 After STOP, the FSM SHALL return to IDLE; if the FIFO is non-empty at that edge, it SHALL pop immediately, so back-to-back frames have no idle gap.
REQ-017 The FIFO empty with a change event at edge E SHALL give oTx=0 starting at edge E+1, i.e. one cycle of latency.
REQ-018 A change event while the FIFO is full with no pop at the same edge SHALL drop the byte and set oOverflow=1.
REQ-019 A change event while the FIFO is full with a pop at the same edge SHALL be accepted; the count is unchanged and oOverflow is unchanged.
REQ-020 oOverflow SHALL clear only by Reset.
REQ-021 oBusy SHALL be registered: 1 when the FSM is not IDLE or the count is greater than 0, otherwise 0.
REQ-022 oTx SHALL be driven from a register and SHALL never glitch within a bit period.

Reset
REQ-023 Reset high at an edge SHALL set oTx=1, oBusy=0, oOverflow=0, FSM=IDLE, FIFO count=0, pointers=0, baud counter=0, rLast=8'h00.
REQ-024 Reset mid-frame SHALL abort the frame; oTx SHALL return to 1 at that edge, and the partial byte and all FIFO contents SHALL be discarded.
REQ-025 While Reset is high, iLed changes SHALL not be captured; the first capture compares against rLast=8'h00.

Configuration
REQ-026 With macro LED_TRACE_PARITY_EN defined, a PARITY state SHALL follow DATA and send even parity (XOR of the 8 data bits) for BAUD_DIV cycles.
REQ-027 With LED_TRACE_PARITY_EN undefined, DATA SHALL go directly to STOP, and no parity logic SHALL be present.

Verification (BAUD_DIV=4, DEPTH=4, parity off unless stated)
REQ-028 Reset, then iLed 00->A5 at edge 10 -> oTx low at edges 11-14, then bits 1,0,1,0,0,1,0,1 (4 cycles each), stop high; oBusy falls after 40 cycles.
REQ-029 iLed held constant at 00 for 200 cycles after reset -> oTx stays 1, oBusy stays 0.
REQ-030 Changes 01,02,03 on consecutive edges -> three back-to-back frames, 120 cycles, no idle gap, in order 01,02,03.
REQ-031 Six distinct changes on consecutive edges with the FIFO initially empty -> first popped immediately, next four stored, sixth dropped; oOverflow=1 and sticky after the frames drain.
REQ-032 Reset asserted 17 cycles into frame 3C with two entries queued -> oTx=1 at that edge, oBusy=0, no further frames.
REQ-033 With LED_TRACE_PARITY_EN, iLed 00->07 -> 44-cycle frame with parity bit 1 before stop.

Source files
------------

// File: rtl/led_trace_tx.sv
// LED change tracer: logs every change of iLed into a small FIFO and sends each byte as an 8N1 UART frame on oTx.
// Define LED_TRACE_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module led_trace_tx #(
    parameter int BAUD_DIV = 16,
    parameter int DEPTH    = 4
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] iLed,
    output logic       oTx,
    output logic       oBusy,
    output logic       oOverflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [7:0]    RELOAD = 8'(BAUD_DIV - 1);
    localparam logic [CW-1:0] FULL   = CW'(DEPTH);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] STOP   = 3'd4;
`ifdef LED_TRACE_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
`endif

    logic [7:0]    rLast;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [CW-1:0] count, count_n;

    logic [2:0] state, state_n;
    logic [7:0] baud, baud_n;
    logic [2:0] bitidx, bitidx_n;
    logic [7:0] shreg, shreg_n;
    logic       tx_n;
`ifdef LED_TRACE_PARITY_EN
    logic       par, par_n;
`endif

    logic change, pop, push, drop, bit_end;

    assign change  = (iLed != rLast);
    assign bit_end = (baud == 8'd0);
    // A pop happens from IDLE or exactly at the end of STOP, so frames chain without a gap.
    assign pop     = (count != '0) && ((state == IDLE) || ((state == STOP) && bit_end));
    // A full FIFO still accepts the new byte when an entry leaves on the same edge.
    assign push    = change && ((count != FULL) || pop);
    assign drop    = change && !push;

    always_comb begin
        case ({push, pop})
            2'b10:   count_n = count + CW'(1);
            2'b01:   count_n = count - CW'(1);
            default: count_n = count;
        endcase
    end

    always_comb begin
        state_n  = state;
        baud_n   = baud;
        bitidx_n = bitidx;
        shreg_n  = shreg;
        tx_n     = oTx;
`ifdef LED_TRACE_PARITY_EN
        par_n    = par;
`endif
        if (pop) begin
            state_n = START;
            shreg_n = mem[rptr];
            baud_n  = RELOAD;
            tx_n    = 1'b0;
`ifdef LED_TRACE_PARITY_EN
            par_n   = ^mem[rptr];
`endif
        end else begin
            case (state)
                IDLE: tx_n = 1'b1;
                START: begin
                    if (bit_end) begin
                        state_n  = DATA;
                        bitidx_n = 3'd0;
                        tx_n     = shreg[0];
                        baud_n   = RELOAD;
                    end else begin
                        baud_n = baud - 8'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_n = RELOAD;
                        if (bitidx == 3'd7) begin
`ifdef LED_TRACE_PARITY_EN
                            state_n = PARITY;
                            tx_n    = par;
`else
                            state_n = STOP;
                            tx_n    = 1'b1;
`endif
                        end else begin
                            bitidx_n = bitidx + 3'd1;
                            shreg_n  = shreg >> 1;
                            tx_n     = shreg[1];
                        end
                    end else begin
                        baud_n = baud - 8'd1;
                    end
                end
`ifdef LED_TRACE_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                        baud_n  = RELOAD;
                    end else begin
                        baud_n = baud - 8'd1;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        state_n = IDLE;
                        tx_n    = 1'b1;
                    end else begin
                        baud_n = baud - 8'd1;
                    end
                end
                default: begin
                    state_n = IDLE;
                    tx_n    = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset && push) begin
            mem[wptr] <= iLed;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            rLast     <= 8'h00;
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            state     <= IDLE;
            baud      <= '0;
            bitidx    <= '0;
            shreg     <= '0;
            oTx       <= 1'b1;
            oBusy     <= 1'b0;
            oOverflow <= 1'b0;
`ifdef LED_TRACE_PARITY_EN
            par       <= 1'b0;
`endif
        end else begin
            rLast     <= iLed;
            wptr      <= wptr + AW'(push);
            rptr      <= rptr + AW'(pop);
            count     <= count_n;
            state     <= state_n;
            baud      <= baud_n;
            bitidx    <= bitidx_n;
            shreg     <= shreg_n;
            oTx       <= tx_n;
            oBusy     <= (state_n != IDLE) || (count_n != '0);
            oOverflow <= oOverflow | drop;
`ifdef LED_TRACE_PARITY_EN
            par       <= par_n;
`endif
        end
    end

endmodule

// File: tb/tb_led_trace_tx.sv
// Randomized scoreboard bench for led_trace_tx: a queue-level model predicts each frame's byte and start edge,
// a serial monitor decodes oTx and compares against the expected queue.
module tb_led_trace_tx;

    localparam int B = 4;
    localparam int D = 4;
`ifdef LED_TRACE_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * B;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] iLed  = 8'h00;
    logic       oTx, oBusy, oOverflow;

    led_trace_tx #(.BAUD_DIV(B), .DEPTH(D)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .iLed     (iLed),
        .oTx      (oTx),
        .oBusy    (oBusy),
        .oOverflow(oOverflow)
    );

    always #5 Clock = ~Clock;

    int unsigned cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    typedef struct {
        logic [7:0]  data;
        int unsigned start;
    } exp_t;

    exp_t        expq[$];
    logic [7:0]  mfifo[$];
    int unsigned free_at = 0;
    logic [7:0]  mlast = 8'h00;
    bit          movf = 1'b0;
    int unsigned epoch = 0;
    bit          mon_busy = 1'b0;
    int unsigned frames_seen = 0;
    int          checks = 0;
    int          errors = 0;

    function automatic logic exp_bit(input logic [7:0] d, input int j);
        if (j == 0) return 1'b0;
        if (j <= 8) return d[j-1];
`ifdef LED_TRACE_PARITY_EN
        if (j == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, cyc, act, req);
        end
    endtask

    // One clock edge: drive inputs, then advance the reference model by the same edge.
    task automatic step(input logic [7:0] v, input bit rst);
        exp_t e;
        iLed  = v;
        Reset = rst;
        @(posedge Clock);
        #1;
        if (rst) begin
            mfifo.delete();
            expq.delete();
            free_at = cyc;
            mlast   = 8'h00;
            movf    = 1'b0;
            epoch++;
        end else begin
            if (mfifo.size() > 0 && cyc >= free_at) begin
                e.data  = mfifo.pop_front();
                e.start = cyc;
                expq.push_back(e);
                free_at = cyc + FRAME;
            end
            if (v != mlast) begin
                if (mfifo.size() < D) mfifo.push_back(v);
                else movf = 1'b1;
            end
            mlast = v;
        end
        check("busy", 32'(oBusy), 32'((cyc < free_at) || (mfifo.size() > 0)));
        check("overflow", 32'(oOverflow), 32'(movf));
        if (cyc >= free_at) check("tx_idle", 32'(oTx), 32'd1);
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (mfifo.size() == 0 && cyc >= free_at && expq.size() == 0 && !mon_busy) begin
                done = 1'b1;
                break;
            end
            step(mlast, 1'b0);
        end
        check("drain_done", 32'(done), 32'd1);
        for (int i = 0; i < 3; i++) step(mlast, 1'b0);
    endtask

    // Serial monitor: sampled on the falling edge, away from the DUT's active edge.
    initial begin
        exp_t        e;
        int unsigned s, ep;
        int          bad;
        bit          have;
        logic [7:0]  d;
        forever begin
            @(negedge Clock);
            if (!Reset && oTx === 1'b0) begin
                mon_busy = 1'b1;
                s   = cyc;
                ep  = epoch;
                bad = 0;
                if (expq.size() == 0) begin
                    have = 1'b0;
                    d    = 8'h00;
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame at edge %0d: got start bit, expected idle line", cyc);
                end else begin
                    have = 1'b1;
                    e    = expq.pop_front();
                    d    = e.data;
                end
                for (int i = 0; i < FRAME; i++) begin
                    if (i > 0) @(negedge Clock);
                    if (oTx !== exp_bit(d, i / B)) bad++;
                end
                if (have && epoch == ep) begin
                    check("frame_bits", 32'(bad), 32'd0);
                    check("frame_start", s, e.start);
                    frames_seen++;
                end
                mon_busy = 1'b0;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1);
    end

    initial begin
        int unsigned f0;
        logic [7:0]  v;
        int          r, n;

        for (int i = 0; i < 3; i++) step(8'h00, 1'b1);

        for (int i = 0; i < 200; i++) step(8'h00, 1'b0);

        for (int i = 0; i < 6; i++) step(8'h00, 1'b0);
        step(8'hA5, 1'b0);
        drain();

        f0 = frames_seen;
        step(8'h01, 1'b0);
        step(8'h02, 1'b0);
        step(8'h03, 1'b0);
        drain();
        check("three_frames", frames_seen - f0, 32'd3);

        step(8'h11, 1'b0);
        step(8'h22, 1'b0);
        step(8'h33, 1'b0);
        step(8'h44, 1'b0);
        step(8'h55, 1'b0);
        step(8'h66, 1'b0);
        drain();
        check("overflow_sticky", 32'(oOverflow), 32'd1);

        for (int i = 0; i < 2; i++) step(8'h00, 1'b1);
        step(8'h3C, 1'b0);
        step(8'h02, 1'b0);
        step(8'h04, 1'b0);
        for (int i = 0; i < 15; i++) step(8'h04, 1'b0);
        step(8'h00, 1'b1);
        check("abort_tx", 32'(oTx), 32'd1);
        check("abort_busy", 32'(oBusy), 32'd0);
        f0 = frames_seen;
        for (int i = 0; i < 60; i++) step(8'h00, 1'b0);
        check("no_frames_after_abort", frames_seen - f0, 32'd0);

        step(8'h07, 1'b0);
        drain();

        for (int k = 0; k < 3000; k++) begin
            r = int'($urandom_range(0, 99));
            if (r < 12) begin
                step(8'($urandom), 1'b0);
            end else if (r < 16) begin
                n = int'($urandom_range(3, 6));
                for (int j = 0; j < n; j++) begin
                    v = mlast ^ 8'($urandom_range(1, 255));
                    step(v, 1'b0);
                end
            end else begin
                step(mlast, 1'b0);
            end
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
